// File: rtl/var_delay_pipe_if.sv
// Bundle of data, handshake and configuration signals for var_delay_pipe.
// The master drives traffic and configuration; the slave is the delay line.
interface var_delay_pipe_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 1,
  parameter int DELAY_W  = 5
);
  logic [DELAY_W-1:0]        cfg_delay;
  logic                      cfg_load;
  logic                      cfg_busy;
  logic [DELAY_W-1:0]        cur_delay;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      in_ready;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [DELAY_W-1:0]        occupancy;

  modport master (
    output cfg_delay, cfg_load, in_valid, in_data,
    input  cfg_busy, cur_delay, in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  cfg_delay, cfg_load, in_valid, in_data,
    output cfg_busy, cur_delay, in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/var_delay_pipe.sv
// Multi-lane delay line with runtime-programmable latency of 1..MAX_DELAY enabled cycles.
// Reprogramming drains in-flight traffic before the new latency takes effect.
module var_delay_pipe #(
  parameter int WIDTH         = 32,
  parameter int CHANNELS      = 1,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 4,
  parameter int DELAY_W       = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  var_delay_pipe_if.slave  bus
);

  localparam int DEPTH = (MAX_DELAY > 1) ? MAX_DELAY - 1 : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW    = CHANNELS * WIDTH;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOAD} state_e;

  function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] req);
    if (req == '0) return DELAY_W'(1);
    if (req > DELAY_W'(MAX_DELAY)) return DELAY_W'(MAX_DELAY);
    return req;
  endfunction

  // Read pointer trails the write pointer by D-1 entries, modulo DEPTH.
  function automatic logic [PTR_W-1:0] rd_start(input logic [DELAY_W-1:0] d);
    logic [DELAY_W-1:0] dm1;
    dm1 = d - DELAY_W'(1);
    if (dm1 == '0 || dm1 >= DELAY_W'(DEPTH)) return '0;
    return PTR_W'(DELAY_W'(DEPTH) - dm1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_e              state_q, state_d;
  logic [DELAY_W-1:0]  cur_delay_q, cur_delay_d;
  logic [DELAY_W-1:0]  pend_q, pend_d;
  logic [DELAY_W-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CHANNELS-1:0] out_vld_q, out_vld_d;
  logic [DW-1:0]       out_dat_q, out_dat_d;

  logic [CHANNELS-1:0] buf_vld_q [DEPTH];
  logic [DW-1:0]       buf_dat_q [DEPTH];

  logic                in_ready;
  logic                bypass;
  logic                wr_en;
  logic                clr_buf;
  logic [CHANNELS-1:0] slot_vld;
  logic [CHANNELS-1:0] mv_vld;
  logic [DW-1:0]       mv_dat;

  assign in_ready = (state_q == S_RUN);
  assign slot_vld = bus.in_valid & {CHANNELS{in_ready}};
  // With D=1 the incoming slot goes straight into the output register.
  assign bypass   = (cur_delay_q == DELAY_W'(1));
  assign mv_vld   = bypass ? slot_vld    : buf_vld_q[rd_ptr_q];
  assign mv_dat   = bypass ? bus.in_data : buf_dat_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    cur_delay_d = cur_delay_q;
    pend_d      = pend_q;
    occ_d       = occ_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    wr_en       = 1'b0;
    clr_buf     = 1'b0;
    if (en) begin
      out_vld_d = mv_vld;
      out_dat_d = mv_dat;
      occ_d     = occ_q + DELAY_W'(|slot_vld) - DELAY_W'(|mv_vld);
      if (!bypass) begin
        wr_en    = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case (state_q)
        S_RUN: begin
          if (bus.cfg_load) begin
            pend_d  = clamp_delay(bus.cfg_delay);
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (occ_q == '0) state_d = S_LOAD;
        end
        S_LOAD: begin
          cur_delay_d = pend_q;
          wr_ptr_d    = '0;
          rd_ptr_d    = rd_start(pend_q);
          occ_d       = '0;
          wr_en       = 1'b0;
          clr_buf     = 1'b1;
          state_d     = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Control and output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      cur_delay_q <= DELAY_W'(DEFAULT_DELAY);
      pend_q      <= DELAY_W'(DEFAULT_DELAY);
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= rd_start(DELAY_W'(DEFAULT_DELAY));
      out_vld_q   <= '0;
      out_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_delay_q <= cur_delay_d;
      pend_q      <= pend_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
    end
  end

  // Circular buffer stage: valid bits are cleared on reset and on reload, data is not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_vld_q[i] <= '0;
    end else if (clr_buf) begin
      for (int i = 0; i < DEPTH; i++) buf_vld_q[i] <= '0;
    end else if (wr_en) begin
      buf_vld_q[wr_ptr_q] <= slot_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_dat_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready;
  assign bus.cfg_busy  = (state_q != S_RUN);
  assign bus.cur_delay = cur_delay_q;
  assign bus.occupancy = occ_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_dat_q;

endmodule

// File: tb/tb_var_delay_pipe.sv
// Bench for var_delay_pipe: directed scenarios plus randomized traffic checked
// against a timestamp-based model of the delay line and its reconfiguration rules.
module tb_var_delay_pipe;
  localparam int W    = 32;
  localparam int CH   = 2;
  localparam int MAXD = 16;
  localparam int DEFD = 4;
  localparam int DW   = $clog2(MAXD + 1);

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  var_delay_pipe_if #(.WIDTH(W), .CHANNELS(CH), .DELAY_W(DW)) bus ();

  var_delay_pipe #(.WIDTH(W), .CHANNELS(CH), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD), .DELAY_W(DW))
    dut (.clk(clk), .rst(rst), .en(en), .bus(bus));

  typedef struct {
    logic [CH-1:0]   v;
    logic [CH*W-1:0] d;
    int              due;
  } samp_t;

  // Model: accepted samples with the enabled-edge index at which they reach the output.
  samp_t           q[$];
  int              n;
  int              m_d, m_pend, m_mode; // mode 0 RUN, 1 DRAIN, 2 LOAD
  logic [CH-1:0]   m_vld;
  logic [CH*W-1:0] m_dat;
  bit              m_dchk;
  int              total = 0;
  int              bad = 0;

  task automatic model_reset();
    q.delete();
    n = 0; m_d = DEFD; m_pend = DEFD; m_mode = 0;
    m_vld = '0; m_dat = '0; m_dchk = 1'b1;
  endtask

  task automatic model_edge(input bit e, input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                            input bit ld, input int cd);
    int occ0;
    samp_t s;
    if (!e) return;
    occ0 = q.size();
    if (m_mode == 0 && v != '0) begin
      s.v = v; s.d = d; s.due = n + m_d - 1;
      q.push_back(s);
    end
    case (m_mode)
      0: if (ld) begin
           m_pend = (cd == 0) ? 1 : ((cd > MAXD) ? MAXD : cd);
           m_mode = 1;
         end
      1: if (occ0 == 0) m_mode = 2;
      default: begin m_d = m_pend; m_mode = 0; end
    endcase
    m_vld = '0; m_dchk = 1'b0;
    if (q.size() > 0 && q[0].due == n) begin
      m_vld = q[0].v; m_dat = q[0].d; m_dchk = 1'b1;
      void'(q.pop_front());
    end
    n++;
  endtask

  task automatic tick(input bit e, input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                      input bit ld, input int cd);
    en = e; bus.in_valid = v; bus.in_data = d; bus.cfg_load = ld; bus.cfg_delay = DW'(cd);
    @(posedge clk);
    model_edge(e, v, d, ld, cd);
    #1;
  endtask

  task automatic set_delay(input int cd, input int expd);
    tick(1'b1, '0, '0, 1'b1, cd);
    for (int i = 0; i < 60 && bus.cfg_busy === 1'b1; i++) tick(1'b1, '0, '0, 1'b0, 0);
    total++;
    if (bus.cfg_busy !== 1'b0 || bus.cur_delay !== DW'(expd)) begin
      bad++;
      $display("FAIL set_delay busy=%b cur=%0d required busy=0 cur=%0d", bus.cfg_busy, bus.cur_delay, expd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    bus.in_valid = '0; bus.in_data = '0; bus.cfg_load = 1'b0; bus.cfg_delay = '0;
    model_reset();
    #23;
    total++;
    if ({bus.out_valid, bus.in_ready, bus.cfg_busy, bus.cur_delay, bus.occupancy, bus.out_data} !==
        {2'b00, 1'b1, 1'b0, DW'(4), DW'(0), 64'h0}) begin
      bad++;
      $display("FAIL reset_values vld=%b rdy=%b busy=%b cur=%0d occ=%0d data=%h", bus.out_valid,
               bus.in_ready, bus.cfg_busy, bus.cur_delay, bus.occupancy, bus.out_data);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(k[0], '0, '0, 1'b0, 0);
      total++;
      if ({bus.out_valid, bus.in_ready, bus.cfg_busy, bus.cur_delay, bus.occupancy} !==
          {m_vld, m_mode == 0, m_mode != 0, DW'(m_d), DW'(q.size())}) begin
        bad++;
        $display("FAIL after_reset k=%0d got=%h required=%h", k,
                 {bus.out_valid, bus.in_ready, bus.cfg_busy, bus.cur_delay, bus.occupancy},
                 {m_vld, m_mode == 0, m_mode != 0, DW'(m_d), DW'(q.size())});
      end
    end
  endtask

  task automatic test_single();
    int lat = -1;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, (k == 1) ? 2'b01 : 2'b00, {32'h0, 32'hA5}, 1'b0, 0);
      total++;
      if ({bus.out_valid, bus.occupancy} !== {m_vld, DW'(q.size())}) begin
        bad++;
        $display("FAIL single_state k=%0d got=%h required=%h", k, {bus.out_valid, bus.occupancy},
                 {m_vld, DW'(q.size())});
      end
      if (m_dchk) begin
        total++;
        if (bus.out_data !== m_dat) begin
          bad++; $display("FAIL single_data k=%0d got=%h required=%h", k, bus.out_data, m_dat);
        end
      end
      if (bus.out_valid[0] === 1'b1 && lat < 0) lat = k;
    end
    // Sample presented after edge 0 of this loop; latency counted in edges from there.
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL single_latency got=%0d required=4", lat);
    end
  endtask

  task automatic test_reconfig();
    int req[3]  = '{2, 0, 31};
    int expd[3] = '{2, 1, 16};
    int lat;
    bit busy_seen;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) tick(1'b1, 2'b01, {32'h0, 32'(j * 16 + i)}, 1'b0, 0);
      tick(1'b1, 2'b11, {32'hBEEF, 32'(j * 16 + 3)}, 1'b1, req[j]);
      busy_seen = 1'b0;
      for (int i = 0; i < 40 && bus.cfg_busy === 1'b1; i++) begin
        busy_seen = 1'b1;
        total++;
        if (bus.in_ready !== 1'b0) begin
          bad++; $display("FAIL drain_ready j=%0d got=%b required=0", j, bus.in_ready);
        end
        tick(1'b1, 2'b11, {32'hDEAD, 32'hDEAD}, 1'b0, 0);
        total++;
        if ({bus.out_valid, bus.in_ready, bus.cfg_busy, bus.cur_delay, bus.occupancy} !==
            {m_vld, m_mode == 0, m_mode != 0, DW'(m_d), DW'(q.size())}) begin
          bad++;
          $display("FAIL drain_state j=%0d i=%0d got=%h required=%h", j, i,
                   {bus.out_valid, bus.in_ready, bus.cfg_busy, bus.cur_delay, bus.occupancy},
                   {m_vld, m_mode == 0, m_mode != 0, DW'(m_d), DW'(q.size())});
        end
        if (m_dchk) begin
          total++;
          if (bus.out_data !== m_dat) begin
            bad++; $display("FAIL drain_data j=%0d got=%h required=%h", j, bus.out_data, m_dat);
          end
        end
      end
      total++;
      if (busy_seen !== 1'b1 || bus.cfg_busy !== 1'b0 || bus.cur_delay !== DW'(expd[j])) begin
        bad++;
        $display("FAIL reconfig j=%0d busy_seen=%b busy=%b cur=%0d required cur=%0d", j, busy_seen,
                 bus.cfg_busy, bus.cur_delay, expd[j]);
      end
      lat = -1;
      for (int k = 0; k < 30 && lat < 0; k++) begin
        tick(1'b1, (k == 1) ? 2'b10 : 2'b00, {32'(100 + j), 32'h0}, 1'b0, 0);
        if (bus.out_valid[1] === 1'b1) lat = k;
      end
      total++;
      if (lat !== expd[j]) begin
        bad++; $display("FAIL new_latency j=%0d got=%0d required=%0d", j, lat, expd[j]);
      end
    end
  endtask

  task automatic test_long_d16();
    int nxt = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1'b1, (k < 40) ? {1'($urandom), 1'b1} : 2'b00, {$urandom, 32'(k)}, 1'b0, 0);
      total++;
      if ({bus.out_valid, bus.occupancy} !== {m_vld, DW'(q.size())} || bus.occupancy > DW'(16)) begin
        bad++;
        $display("FAIL d16_state k=%0d got=%h required=%h", k, {bus.out_valid, bus.occupancy},
                 {m_vld, DW'(q.size())});
      end
      if (bus.out_valid[0] === 1'b1) begin
        total++;
        if (bus.out_data !== m_dat || bus.out_data[31:0] !== 32'(nxt)) begin
          bad++; $display("FAIL d16_order k=%0d got=%h required lane0=%0d", k, bus.out_data, nxt);
        end
        nxt++;
      end
    end
    total++;
    if (nxt !== 40) begin
      bad++; $display("FAIL d16_count got=%0d required=40", nxt);
    end
  endtask

  task automatic test_stall();
    int sent = 0;
    int recv = 0;
    bit e;
    logic [CH-1:0]   pv;
    logic [CH*W-1:0] pd;
    logic [DW-1:0]   po;
    for (int k = 0; k < 32; k++) begin
      e = !(k >= 8 && k < 11);
      pv = bus.out_valid; pd = bus.out_data; po = bus.occupancy;
      tick(e, (sent < 20) ? 2'b01 : 2'b00, {32'h0, 32'(sent)}, 1'b0, 0);
      if (e && sent < 20) sent++;
      if (!e) begin
        total++;
        if (bus.out_valid !== pv || bus.out_data !== pd || bus.occupancy !== po) begin
          bad++; $display("FAIL stall_frozen k=%0d got=%h/%0d required=%h/%0d", k, bus.out_valid,
                          bus.occupancy, pv, po);
        end
      end
      total++;
      if ({bus.out_valid, bus.occupancy} !== {m_vld, DW'(q.size())}) begin
        bad++;
        $display("FAIL stall_state k=%0d got=%h required=%h", k, {bus.out_valid, bus.occupancy},
                 {m_vld, DW'(q.size())});
      end
      if (e && bus.out_valid[0] === 1'b1) begin
        total++;
        if (bus.out_data[31:0] !== 32'(recv)) begin
          bad++; $display("FAIL stall_order k=%0d got=%0d required=%0d", k, bus.out_data[31:0], recv);
        end
        recv++;
      end
    end
    total++;
    if (recv !== 20) begin
      bad++; $display("FAIL stall_count got=%0d required=20", recv);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      tick($urandom_range(0, 3) != 0, 2'($urandom), {$urandom, $urandom},
           $urandom_range(0, 29) == 0, int'($urandom_range(0, 31)));
      total++;
      if ({bus.out_valid, bus.in_ready, bus.cfg_busy, bus.cur_delay, bus.occupancy} !==
          {m_vld, m_mode == 0, m_mode != 0, DW'(m_d), DW'(q.size())}) begin
        bad++;
        $display("FAIL rand_state k=%0d got=%h required=%h", k,
                 {bus.out_valid, bus.in_ready, bus.cfg_busy, bus.cur_delay, bus.occupancy},
                 {m_vld, m_mode == 0, m_mode != 0, DW'(m_d), DW'(q.size())});
      end
      if (m_dchk) begin
        total++;
        if (bus.out_data !== m_dat) begin
          bad++; $display("FAIL rand_data k=%0d got=%h required=%h", k, bus.out_data, m_dat);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 12; k++) tick(1'b1, 2'($urandom), {$urandom, $urandom}, 1'b0, 0);
    rst = 1'b1;
    #2;
    total++;
    if ({bus.out_valid, bus.occupancy, bus.cfg_busy, bus.cur_delay, bus.out_data} !==
        {2'b00, DW'(0), 1'b0, DW'(4), 64'h0}) begin
      bad++;
      $display("FAIL reset_mid vld=%b occ=%0d busy=%b cur=%0d data=%h", bus.out_valid,
               bus.occupancy, bus.cfg_busy, bus.cur_delay, bus.out_data);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick(1'b1, (k == 5) ? 2'b11 : 2'b00, {32'h1111, 32'h2222}, 1'b0, 0);
      total++;
      if ({bus.out_valid, bus.occupancy, bus.cur_delay} !== {m_vld, DW'(q.size()), DW'(m_d)}) begin
        bad++;
        $display("FAIL post_reset k=%0d got=%h required=%h", k,
                 {bus.out_valid, bus.occupancy, bus.cur_delay}, {m_vld, DW'(q.size()), DW'(m_d)});
      end
      if (m_dchk) begin
        total++;
        if (bus.out_data !== m_dat) begin
          bad++; $display("FAIL post_reset_data k=%0d got=%h required=%h", k, bus.out_data, m_dat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reconfig();
    test_long_d16();
    set_delay(4, 4);
    test_stall();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
